aes_128_core: RTL and testbench



---
 rtl/aes_pkg.sv | 86 ++++++++
 rtl/aes_128_core_if.sv | 19 +
 rtl/aes_128_round.sv | 52 +++++
 rtl/aes_128_core.sv | 75 +++++++
 tb/tb_aes_128_core.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 arithmetic helpers shared by the core and its round stages.
// Holds the forward S-box, the round constants, GF(2^8) xtime, and the
// whole-block transforms SubBytes / ShiftRows / MixColumns plus one step of
// the key expansion. Blocks are 128-bit, byte 0 in [127:120], column-major:
// word c is bytes 4c..4c+3, and byte r of a word is row r.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // element 0 is the most significant byte, i.e. FIPS byte 0
  typedef logic [0:15][7:0] blk_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // row r of column c takes row r of column (c+r) mod 4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    blk_t b;
    b = s;
    return {b[0],  b[5],  b[10], b[15],
            b[4],  b[9],  b[14], b[3],
            b[8],  b[13], b[2],  b[7],
            b[12], b[1],  b[6],  b[11]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  // one round of key expansion: k_{i-1} -> k_i
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_128_core_if.sv
// Data bus of aes_128_core.
//   state, key : 128-bit plaintext block and cipher key (front end -> core)
//   out        : 128-bit ciphertext (core -> consumer)
//   in_valid / out_valid : slot marker, only with AES_128_VALID_EN defined
interface aes_128_core_if;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
`ifdef AES_128_VALID_EN
  logic         in_valid;
  logic         out_valid;

  modport master (output state, key, in_valid, input out, out_valid);
  modport slave  (input state, key, in_valid, output out, out_valid);
`else
  modport master (output state, key, input out);
  modport slave  (input state, key, output out);
`endif
endinterface

// File: rtl/aes_128_round.sv
// One AES-128 round with its own slice of key expansion.
//   clk, rst : clock, async active-high reset (clears all stage registers)
//   s_in/k_in  : state after the previous round and the key k_{ROUND-1}
//   s_out/k_out: state after this round and k_ROUND
// FINAL=0: stage A registers SubBytes+ShiftRows and k_ROUND; stage B
//          registers MixColumns+AddRoundKey and forwards k_ROUND, so the key
//          travels in lockstep with the block that owns it.
// FINAL=1: single stage SubBytes+ShiftRows+AddRoundKey, no MixColumns;
//          k_out is the combinational k_ROUND and is normally left open.
module aes_128_round
  import aes_pkg::*;
#(
  parameter int ROUND = 1,
  parameter bit FINAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_in,
  input  logic [127:0] k_in,
  output logic [127:0] s_out,
  output logic [127:0] k_out
);

  localparam logic [7:0] RC = RCON[ROUND];

  logic [127:0] nk;
  assign nk = next_key(k_in, RC);

  if (FINAL) begin : g_final
    always_ff @(posedge clk or posedge rst) begin
      if (rst) s_out <= '0;
      else     s_out <= shift_rows(sub_bytes(s_in)) ^ nk;
    end
    assign k_out = nk;
  end else begin : g_mid
    logic [127:0] sa_q, ka_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sa_q  <= '0;
        ka_q  <= '0;
        s_out <= '0;
        k_out <= '0;
      end else begin
        sa_q  <= shift_rows(sub_bytes(s_in));
        ka_q  <= nk;
        s_out <= mix_columns(sa_q) ^ ka_q;
        k_out <= ka_q;
      end
    end
  end

endmodule

// File: rtl/aes_128_core.sv
// Fully pipelined AES-128 encryptor, one block per clock, fixed latency:
// inputs sampled at edge N show on bus.out after edge N+20.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every pipeline register
//   bus : aes_128_core_if.slave (state, key in; out registered)
// Ranks: stage 0 (initial AddRoundKey), rounds 1-9 at two ranks each, the
// final round, and the out register -- 21 in all.
// Optional: define AES_128_VALID_EN to carry in_valid -> out_valid through a
// 21-flop shift register alongside the data; the data path is never gated.
module aes_128_core
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  aes_128_core_if.slave  bus
);

  logic [127:0] s0_q, k0_q, out_q;
  logic [127:0] s_rnd [0:NUM_ROUNDS];
  logic [127:0] k_rnd [0:NUM_ROUNDS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= '0;
      k0_q <= '0;
    end else begin
      s0_q <= bus.state ^ bus.key;
      k0_q <= bus.key;
    end
  end

  assign s_rnd[0] = s0_q;
  assign k_rnd[0] = k0_q;

  for (genvar r = 1; r < NUM_ROUNDS; r++) begin : g_round
    aes_128_round #(.ROUND(r), .FINAL(1'b0)) u_round (
      .clk   (clk),
      .rst   (rst),
      .s_in  (s_rnd[r-1]),
      .k_in  (k_rnd[r-1]),
      .s_out (s_rnd[r]),
      .k_out (k_rnd[r])
    );
  end

  aes_128_round #(.ROUND(NUM_ROUNDS), .FINAL(1'b1)) u_final (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_rnd[NUM_ROUNDS-1]),
    .k_in  (k_rnd[NUM_ROUNDS-1]),
    .s_out (s_rnd[NUM_ROUNDS]),
    .k_out ()
  );

  // extra rank behind the final round brings the depth to 21
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= s_rnd[NUM_ROUNDS];
  end

  assign bus.out = out_q;

`ifdef AES_128_VALID_EN
  localparam int STAGES = 20;
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
  end

  assign bus.out_valid = vld_pipe[STAGES];
`endif

endmodule

// File: tb/tb_aes_128_core.sv
// Self-checking bench for aes_128_core: known-answer vectors applied singly
// and back-to-back, plus an async reset with blocks in flight. Expected
// ciphertexts go into a scoreboard tagged with the cycle they are due.
module tb_aes_128_core;

  typedef struct {
    logic [127:0] st;
    logic [127:0] k;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    int           due;
    int           tag;
    logic [127:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  vec_t vec [5];
  sb_t  sb [$];
  sb_t  cur;

  aes_128_core_if bus ();

  aes_128_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t, need finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, need %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    @(negedge clk);
    bus.state = vec[i].st;
    bus.key   = vec[i].k;
`ifdef AES_128_VALID_EN
    bus.in_valid = 1'b1;
`endif
    // sampled at the next edge (cyc+1), visible after edge cyc+1+20
    sb.push_back('{due: cyc + 21, tag: i, exp: vec[i].exp});
  endtask

  task automatic idle();
    @(negedge clk);
`ifdef AES_128_VALID_EN
    bus.in_valid = 1'b0;
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 60) begin
      idle();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL drain: %0d results outstanding, need 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      cur = sb.pop_front();
      chk($sformatf("ct_vec%0d", cur.tag), bus.out, cur.exp);
`ifdef AES_128_VALID_EN
      chk("out_valid", {127'd0, bus.out_valid}, 128'd1);
    end else begin
      chk("out_valid_idle", {127'd0, bus.out_valid}, 128'd0);
`endif
    end
  end

  initial begin
    vec[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32};
    vec[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vec[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vec[3] = '{128'h0, 128'h1, 128'h0545aad56da2a97c3663d1432a3d1c84};
    vec[4] = '{128'h1, 128'h0, 128'h58e2fccefa7e3061367f1d57a4e7455a};

    bus.state = '0;
    bus.key   = '0;
`ifdef AES_128_VALID_EN
    bus.in_valid = 1'b0;
`endif
    #1 rst = 1'b1;
    #1 chk("reset_out", bus.out, 128'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // each vector alone
    for (int i = 0; i < 5; i++) begin
      drive(i);
      idle();
      drain();
    end

    // back to back, different keys every cycle
    for (int i = 0; i < 5; i++) drive(i);
    idle();
    drain();

    // reset with 10 blocks in flight; they must never emerge
    for (int i = 0; i < 10; i++) drive(i % 5);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
`ifdef AES_128_VALID_EN
    bus.in_valid = 1'b0;
`endif
    #1 chk("rst_async_out", bus.out, 128'h0);
`ifdef AES_128_VALID_EN
    chk("rst_async_valid", {127'd0, bus.out_valid}, 128'd0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_hold_out%0d", c), bus.out, 128'h0);
    end
    rst = 1'b0;
    drive(1);
    idle();
    drain();
    for (int i = 0; i < 25; i++) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
